// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default fetch geometry and the PC/instruction types.
package cpu_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int RESET_PC = 0;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [DATA_W-1:0] instr_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer; the head entry drives the consumer from registers.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::ADDR_W,
    parameter int DW = cpu_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic [AW-1:0] i_push_pc,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [1:0]    o_count,
    output logic          o_head_valid,
    output logic [DW-1:0] o_head_data,
    output logic [AW-1:0] o_head_pc
);

    logic [1:0]    r_count;
    logic [DW-1:0] r_data0, r_data1;
    logic [AW-1:0] r_pc0, r_pc1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_pc0   <= '0;
            r_pc1   <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_push_data;
                        r_pc0   <= i_push_pc;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_data1 <= i_push_data;
                        r_pc1   <= i_push_pc;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_pc0   <= r_pc1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_data0 <= i_push_data;
                        r_pc0   <= i_push_pc;
                    end else begin
                        r_data0 <= r_data1;
                        r_pc0   <= r_pc1;
                        r_data1 <= i_push_data;
                        r_pc1   <= i_push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != 2'd0);
    assign o_head_data  = r_data0;
    assign o_head_pc    = r_pc0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues synchronous ROM reads, tags responses with their PC and
// queues them for a valid/ready consumer; redirects flush everything younger.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Handshake: an instruction moves when ins_valid && ins_ready on a rising edge;
    // while ins_valid is high and ins_ready low the head entry is held unchanged.

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_tag;

    logic [1:0]        w_count;
    logic              w_head_valid;
    logic [DATA_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_head_pc;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_space;
    logic              w_issue;

    assign w_pop   = w_head_valid & ins_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_space = (w_occ < 3'd2);
    assign w_issue = fetch_en & ~redirect_valid & ~reset & w_space;
    // A response returning during a redirect belongs to the abandoned path.
    assign w_push  = r_inflight & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RST_PC;
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc  <= r_pc + PC_ONE;
                r_tag <= r_pc;
            end
        end
    end

    fetch_buf #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_data  (rom_dout),
        .i_push_pc    (r_tag),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_head_pc    (w_head_pc)
    );

    assign rom_ce    = w_issue;
    assign rom_oce   = 1'b1;
    assign rom_ad    = reset ? RST_PC : r_pc;
    assign ins_valid = w_head_valid;
    assign ins_data  = w_head_data;
    assign ins_pc    = w_head_pc;

endmodule
